// File: rtl/fetch_sequencer.sv
`default_nettype none
// fetch_sequencer: owns the fetch PC and keeps one instruction-memory read in
// flight at a time. Returned words land in a one-entry buffer toward decode.
module fetch_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int               ILEN       = 32,
  parameter logic [WIDTH-1:0] START_ADDR = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             trap_valid_i,
  input  logic [WIDTH-1:0] trap_pc_i,
  output logic             imem_req_valid_o,
  output logic [WIDTH-1:0] imem_req_addr_o,
  input  logic             imem_req_ready_i,
  input  logic             imem_rsp_valid_i,
  input  logic [ILEN-1:0]  imem_rsp_data_i,
  input  logic             imem_rsp_err_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [ILEN-1:0]  inst_o,
  output logic [WIDTH-1:0] inst_pc_o,
  output logic             inst_fault_o,
  output logic [WIDTH-1:0] pc_o
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             req_valid_q;
  logic             inst_valid_q;
  logic [ILEN-1:0]  inst_q;
  logic [WIDTH-1:0] inst_pc_q;
  logic             inst_fault_q;

  logic             flush_d;
  logic [WIDTH-1:0] flush_pc_d;
  logic [WIDTH-1:0] pc_inc_d;

  // Trap entry outranks a simultaneous branch/jump redirect.
  assign flush_d    = trap_valid_i | redirect_valid_i;
  assign flush_pc_d = trap_valid_i ? trap_pc_i : redirect_pc_i;
  assign pc_inc_d   = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_BOOT;
      pc_q         <= START_ADDR;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          if (flush_d) pc_q <= flush_pc_d;
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
        end
        S_REQ: begin
          if (flush_d) begin
            pc_q <= flush_pc_d;
            // An accepted request still owes a response on the old path.
            if (imem_req_ready_i) begin
              state_q     <= S_DRAIN;
              req_valid_q <= 1'b0;
            end
          end else if (imem_req_ready_i) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (flush_d) begin
            pc_q <= flush_pc_d;
            // A response arriving with the flush is already the wrong-path one.
            if (imem_rsp_valid_i) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (imem_rsp_valid_i) begin
            inst_q       <= imem_rsp_data_i;
            inst_pc_q    <= pc_q;
            inst_fault_q <= imem_rsp_err_i;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (flush_d) begin
            pc_q         <= flush_pc_d;
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
            req_valid_q  <= 1'b1;
          end else if (inst_ready_i) begin
            inst_valid_q <= 1'b0;
            if (inst_fault_q) begin
              state_q <= S_HALT;
            end else begin
              pc_q        <= pc_inc_d;
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (flush_d) begin
            pc_q        <= flush_pc_d;
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (flush_d) pc_q <= flush_pc_d;
          if (imem_rsp_valid_i) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_BOOT;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign inst_fault_o     = inst_fault_q;
  assign pc_o             = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// tb_fetch_sequencer: directed steps plus a randomized phase, checked against a
// transaction-level fetch model and a latency-randomized memory model.
module tb_fetch_sequencer;

  localparam logic [31:0] START = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid, trap_valid;
  logic [31:0] redirect_pc, trap_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, inst_pc, pc;

  int vectors = 0;
  int miscompares = 0;
  int handoffs = 0;

  logic [31:0] exp_pc = START;
  logic        halted = 1'b0;

  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        err_en = 1'b0, err_rand = 1'b0;
  logic        rdy_rand = 1'b0, lat_rand = 1'b0;
  int          mem_lat = 1;

  always #5 clk = ~clk;

  fetch_sequencer #(.WIDTH(32), .ILEN(32), .START_ADDR(START)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .imem_req_valid_o(imem_req_valid), .imem_req_addr_o(imem_req_addr),
    .imem_req_ready_i(imem_req_ready),
    .imem_rsp_valid_i(imem_rsp_valid), .imem_rsp_data_i(imem_rsp_data),
    .imem_rsp_err_i(imem_rsp_err),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_fault_o(inst_fault),
    .pc_o(pc)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return (err_en && a == err_addr) || (err_rand && a[6:2] == 5'd19);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: acts on the falling edge, accepts on valid&ready, answers one
  // word after mem_lat cycles (or a random 1..4).
  initial begin : memory
    logic        pending;
    logic [31:0] paddr;
    int          cnt;
    pending = 1'b0; paddr = '0; cnt = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0; imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(paddr);
          imem_rsp_err   = errf(paddr);
          pending        = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_req_ready = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        chk("one_outstanding", 32'(pending), 32'd0);
        pending = 1'b1;
        paddr   = imem_req_addr;
        cnt     = lat_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
      end
    end
  end

  // One clock: score any handoff against the model, advance the model, and
  // afterwards check buffer stability and halt behaviour.
  task automatic step();
    logic        hand, flush, hold, s_f;
    logic [31:0] tgt, s_inst, s_pc;
    hand   = rst_n && inst_valid && inst_ready;
    flush  = rst_n && (trap_valid || redirect_valid);
    tgt    = trap_valid ? trap_pc : redirect_pc;
    hold   = rst_n && inst_valid && !inst_ready && !flush;
    s_inst = inst; s_pc = inst_pc; s_f = inst_fault;
    if (hand) begin
      chk("handoff_pc", inst_pc, exp_pc);
      chk("handoff_inst", inst, memf(exp_pc));
      chk("handoff_fault", 32'(inst_fault), 32'(errf(exp_pc)));
      handoffs++;
    end
    if (!rst_n) begin
      exp_pc = START; halted = 1'b0;
    end else if (flush) begin
      exp_pc = tgt; halted = 1'b0;
    end else if (hand) begin
      if (errf(exp_pc)) halted = 1'b1;
      else exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (hold && rst_n) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, s_inst);
      chk("hold_pc", inst_pc, s_pc);
      chk("hold_fault", 32'(inst_fault), 32'(s_f));
    end
    if (halted && rst_n) chk("halt_no_req", 32'(imem_req_valid), 32'd0);
  endtask

  initial begin : main
    rst_n = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    chk("rst_pc", pc, START);
    rst_n = 1'b1;

    // Zero-wait memory: one instruction every three cycles.
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t1_req_valid", 32'(imem_req_valid), 32'((k % 3) == 0));
      if ((k % 3) == 0) chk("t1_req_addr", imem_req_addr, START + 32'(4 * (k / 3)));
      chk("t1_inst_valid", 32'(inst_valid), 32'((k % 3) == 2));
      if ((k % 3) == 2) chk("t1_inst_pc", inst_pc, START + 32'(4 * (k / 3)));
    end

    // Decode stalls for five cycles on the 0x80000008 word.
    inst_ready = 1'b0;
    mem_lat = 3;
    for (int i = 0; i < 5; i++) begin
      chk("t2_inst_valid", 32'(inst_valid), 32'd1);
      chk("t2_inst_pc", inst_pc, 32'h8000_0008);
      chk("t2_no_req", 32'(imem_req_valid), 32'd0);
      step();
    end
    chk("t2_still_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    step();
    chk("t2_next_req", 32'(imem_req_valid), 32'd1);
    chk("t2_next_addr", imem_req_addr, 32'h8000_000C);

    // Redirect while a slow response is outstanding.
    step();
    chk("t3_wait", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    mem_lat = 1;
    chk("t3_pc", pc, 32'h8000_1000);
    chk("t3_req_off", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      chk("t3_drop", 32'(inst_valid), 32'd0);
      step();
    end
    chk("t3_req", 32'(imem_req_valid), 32'd1);
    chk("t3_addr", imem_req_addr, 32'h8000_1000);

    // Trap and redirect together while an instruction is held.
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) break;
      step();
    end
    chk("t4_hold", 32'(inst_valid), 32'd1);
    chk("t4_inst_pc", inst_pc, 32'h8000_1000);
    trap_valid = 1'b1; trap_pc = 32'h8000_0100;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    inst_ready = 1'b1;
    chk("t4_inst_valid", 32'(inst_valid), 32'd0);
    chk("t4_req", 32'(imem_req_valid), 32'd1);
    chk("t4_addr", imem_req_addr, 32'h8000_0100);

    // Access fault at 0x80000008 halts fetch until a redirect.
    err_addr = 32'h8000_0008; err_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = START;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid && inst_pc == 32'h8000_0008) break;
      step();
    end
    chk("t5_reach", 32'(inst_valid && inst_pc == 32'h8000_0008), 32'd1);
    chk("t5_fault", 32'(inst_fault), 32'd1);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t5_halt_req", 32'(imem_req_valid), 32'd0);
      chk("t5_halt_inst", 32'(inst_valid), 32'd0);
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    step();
    redirect_valid = 1'b0;
    chk("t5_resume", 32'(imem_req_valid), 32'd1);
    chk("t5_resume_addr", imem_req_addr, 32'h8000_0040);

    // PC wrap, then asynchronous reset in the middle of a fetch.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      step();
    end
    chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) break;
      step();
    end
    chk("t6_top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("t6_wrap_req", 32'(imem_req_valid), 32'd1);
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    step();
    chk("t6_in_wait", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_inst", inst, 32'd0);
    chk("t6_rst_inst_pc", inst_pc, 32'd0);
    chk("t6_rst_fault", 32'(inst_fault), 32'd0);
    chk("t6_rst_pc", pc, START);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_restart_req", 32'(imem_req_valid), 32'd1);
    chk("t6_restart_addr", imem_req_addr, START);
    chk("t6_restart_inst", 32'(inst_valid), 32'd0);

    // Randomized phase: back-pressure, variable latency, faults and flushes.
    err_rand = 1'b1; rdy_rand = 1'b1; lat_rand = 1'b1;
    handoffs = 0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      trap_valid = 1'b0; redirect_valid = 1'b0;
      if (halted ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3)) begin
        if ($urandom_range(0, 1) == 0) trap_valid = 1'b1;
        else redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          trap_valid = 1'b1; redirect_valid = 1'b1;
        end
        trap_pc     = START + 32'(4 * $urandom_range(0, 63));
        redirect_pc = START + 32'h400 + 32'(4 * $urandom_range(0, 63));
      end
      step();
    end
    trap_valid = 1'b0; redirect_valid = 1'b0;
    chk("rand_progress", 32'(handoffs > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
